// File: rtl/dac_wave_sched_if.sv
// Handshake bundle between the sample-rate scheduler and the dual-channel
// SPI DAC writer.
//
// Handshake: the scheduler raises start_o for exactly one cycle to launch a
// two-channel SPI transaction. addr_o is held stable from that cycle until
// the writer returns a one-cycle eod_i pulse. busy_o is high from the start
// cycle through the cycle in which eod_i is accepted. eod_i is only accepted
// while a transaction is outstanding and is ignored otherwise.
//
// Signals:
//   start_o  scheduler -> writer  one-cycle transaction start
//   addr_o   scheduler -> ROM     waveform ROM address
//   busy_o   scheduler -> writer  transaction outstanding
//   eod_i    writer -> scheduler  one-cycle end-of-data pulse
interface dac_wave_sched_if #(
   parameter int AddrWidth = 8
);
   logic                 start_o;
   logic [AddrWidth-1:0] addr_o;
   logic                 busy_o;
   logic                 eod_i;

   modport master (
      output start_o,
      output addr_o,
      output busy_o,
      input  eod_i
   );

   modport slave (
      input  start_o,
      input  addr_o,
      input  busy_o,
      output eod_i
   );
endinterface

// File: rtl/dac_wave_sched.sv
// Sample-rate scheduler for the dual-channel SPI DAC path. A programmable
// divider produces a periodic tick; each accepted tick launches one SPI
// transaction (DAC-A then DAC-B with the same ROM word). The ROM address
// advances on end-of-data and wraps after addr_max_i. Ticks that arrive
// while a transaction is outstanding are dropped and flagged as overruns.
//
// Ports:
//   clk_i        system clock, rising edge
//   rst_i        asynchronous active-low reset
//   en_i         run enable; low blocks new transactions
//   div_i        sample period minus 1, in clk cycles
//   addr_max_i   last ROM address before wrap to 0
//   clr_i        synchronous clear of ovr_o, tout_o and the address
//   dac          handshake bundle (start_o, addr_o, busy_o, eod_i)
//   ovr_o        sticky overrun flag
//   tout_o       sticky end-of-data timeout flag
//   state_o      current FSM state (0 IDLE, 1 START, 2 WAIT)
module dac_wave_sched #(
   parameter int AddrWidth     = 8,
   parameter int DivWidth      = 16,
   parameter int TimeoutCycles = 4095
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 en_i,
   input  logic [DivWidth-1:0]  div_i,
   input  logic [AddrWidth-1:0] addr_max_i,
   input  logic                 clr_i,
   dac_wave_sched_if.master     dac,
   output logic                 ovr_o,
   output logic                 tout_o,
   output logic [1:0]           state_o
);

   localparam int WaitWidth = $clog2(TimeoutCycles + 1);
   localparam logic [WaitWidth-1:0] WaitLast = WaitWidth'(TimeoutCycles - 1);
   localparam logic [WaitWidth-1:0] WaitSat  = WaitWidth'(TimeoutCycles);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      WAIT  = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [DivWidth-1:0]  tick_cnt_q;
   logic [WaitWidth-1:0] wait_cnt_q;
   logic [AddrWidth-1:0] addr_q;
   logic                 tick;
   logic                 eod_acc;
   logic                 tout_hit;
   logic                 ovr_hit;

   // Live >= compare: lowering div_i below the running count fires at once.
   assign tick    = en_i && (tick_cnt_q >= div_i);
   assign ovr_hit = tick && (state_q != IDLE);

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         tick_cnt_q <= '0;
      end else if (!en_i || tick) begin
         tick_cnt_q <= '0;
      end else begin
         tick_cnt_q <= tick_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Timeout fires on the TimeoutCycles-th WAIT cycle without eod_i;
   // eod_i in that same cycle takes precedence.
   always_comb begin
      state_d  = state_q;
      eod_acc  = 1'b0;
      tout_hit = 1'b0;
      case (state_q)
         IDLE: begin
            if (tick) state_d = START;
         end
         START: begin
            state_d = WAIT;
         end
         WAIT: begin
            if (dac.eod_i) begin
               eod_acc = 1'b1;
               state_d = IDLE;
            end else if (wait_cnt_q == WaitLast) begin
               tout_hit = 1'b1;
               state_d  = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         wait_cnt_q <= '0;
      end else if (state_q == START) begin
         wait_cnt_q <= '0;
      end else if ((state_q == WAIT) && (wait_cnt_q != WaitSat)) begin
         wait_cnt_q <= wait_cnt_q + 1'b1;
      end
   end

   // Clear beats increment. The == wrap test means a shrunk addr_max_i
   // below the current address only wraps at the natural counter limit.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         addr_q <= '0;
      end else if (clr_i) begin
         addr_q <= '0;
      end else if (eod_acc) begin
         addr_q <= (addr_q == addr_max_i) ? '0 : addr_q + 1'b1;
      end
   end

   // Set beats clear on the sticky flags.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         ovr_o  <= 1'b0;
         tout_o <= 1'b0;
      end else begin
         if (ovr_hit)    ovr_o <= 1'b1;
         else if (clr_i) ovr_o <= 1'b0;
         if (tout_hit)   tout_o <= 1'b1;
         else if (clr_i) tout_o <= 1'b0;
      end
   end

   assign dac.start_o = (state_q == START);
   assign dac.busy_o  = (state_q != IDLE);
   assign dac.addr_o  = addr_q;
   assign state_o     = state_q;

endmodule
